fib_stream_checker: RTL
=======================

Name: fib_stream_checker

Overview:
Consumer end of the Fibonacci stream generator. It watches the generator's 8-bit output together with the per-cycle advance bit the generator sampled, and locks onto the sequence from two observed terms. It then predicts every following term modulo 2^W and flags mismatches. It sits on the generator's output bus, either as an in-system monitor or as a regression checker.

Parameters:
W, 8, data width; all arithmetic is modulo 2^W, matching the generator's adder.
LOCK_THRESH, 4, consecutive matches in VERIFY needed to enter LOCKED (range 1..15).
ERR_THRESH, 3, consecutive mismatches in LOCKED that force a return to HUNT (range 1..15).
CW, 16, width of err_count.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
obs_valid  in  1  a sample is present this cycle; when 0, all other inputs are ignored and no state changes.
obs_adv  in  1  generator advance bit for this sample: 1 = next term follows, 0 = same term repeats.
obs_data  in  W  observed generator output.
locked  out  1  checker is in LOCKED.
err  out  1  one-cycle pulse: the previous sample mismatched while LOCKED.
lost  out  1  one-cycle pulse: ERR_THRESH consecutive mismatches occurred and lock was dropped.
exp_data  out  W  predicted value of the next sample (exp_a); don't-care in HUNT.
err_count  out  CW  total mismatches in LOCKED, saturating at all-ones.

Behaviour:
- Reset, asynchronous, active-high (rst) on clock clk: state=HUNT, exp_a=exp_b=0, cap=0, hunt_cnt=0, match_cnt=0, miss_cnt=0, locked=0, err=0, lost=0, err_count=0. Applies immediately, including mid-stream. The first sample after release is treated as fresh HUNT input.
- All outputs are registered. The effect of a sample taken at edge N is visible after edge N.
- Model: (exp_a, exp_b) mirrors the generator's (a, b).
- Per valid sample in VERIFY/LOCKED: compare obs_data with exp_a.
  - If obs_adv=1: (exp_a, exp_b) <= (exp_b, exp_a+exp_b mod 2^W).
  - Else: hold exp_a, exp_b.
- HUNT:
  - Ignore samples with obs_adv=0.
  - First adv sample: cap<=obs_data, hunt_cnt<=1.
  - Second adv sample x1: exp_a<=cap+x1, exp_b<=x1+cap+x1 (mod 2^W), match_cnt<=0, go to VERIFY.
- VERIFY:
  - Match: match_cnt++. When it reaches LOCK_THRESH, go to LOCKED (locked=1) and clear miss_cnt.
  - Mismatch: go to HUNT, hunt_cnt<=0. No err pulse, err_count unchanged.
- LOCKED:
  - Match: miss_cnt<=0.
  - Mismatch: err=1 for one cycle, err_count+1 (saturating), miss_cnt++, and the model still advances per obs_adv (no reseed).
  - If miss_cnt reaches ERR_THRESH: lost=1 for one cycle (same cycle as that err), locked<=0, go to HUNT, hunt_cnt<=0.
- obs_valid=0 gaps of any length change nothing; err and lost still fall after one cycle.
- Wrap-around is expected and is not an error (e.g. 233+144 -> 121 when W=8).
- Unused state encoding: recovers to HUNT on the next clock.
- err_count holds at 2^CW-1 and is cleared only by rst.

Test Plan:
1. Reset, then feed 0,1,1,2,3,5 (all adv=1, valid every cycle). Required: locked=1 after the edge sampling 5. exp_data=8 at that point, err never asserted.
2. While locked, continue 8,13,21,34,55,89,144,233,121,98 (adv=1). Required: no err; exp_data reads 219 after the sample 98.
3. While locked, feed 13 with adv=0, then 13 adv=1, then 21 with a 3-cycle obs_valid=0 gap before it. Required: no err, locked stays 1.
4. Locked and expecting 21, feed 22 (adv=1), then 34. Required: err pulses for exactly 1 cycle, err_count=1, exp_data=34 after the 22 sample, miss_cnt cleared after 34, locked stays 1.
5. Locked, feed 3 consecutive wrong values (adv=1). Required: err pulses 3 times, lost pulses with the third err, locked=0, err_count=3. A subsequent 5,8 followed by LOCK_THRESH correct terms relocks.
6. Assert rst for 1 cycle mid-LOCKED, asynchronously between edges. Required: locked, err, lost and err_count read 0 immediately. Relock then needs the full HUNT+VERIFY sequence again.

Source files
------------

// File: rtl/fib_stream_checker.sv
// Fibonacci stream checker: locks onto a generator's output from two observed
// terms, then predicts every following term modulo 2^W and reports mismatches.
module fib_stream_checker #(
    parameter int W           = 8,
    parameter int LOCK_THRESH = 4,
    parameter int ERR_THRESH  = 3,
    parameter int CW          = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          obs_valid,
    input  logic          obs_adv,
    input  logic [W-1:0]  obs_data,
    output logic          locked,
    output logic          err,
    output logic          lost,
    output logic [W-1:0]  exp_data,
    output logic [CW-1:0] err_count
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'b00,
        ST_VERIFY = 2'b01,
        ST_LOCKED = 2'b10
    } state_e;

    localparam logic [3:0] LOCK_T = 4'(LOCK_THRESH);
    localparam logic [3:0] ERR_T  = 4'(ERR_THRESH);

    state_e        state_q, state_d;
    logic [W-1:0]  exp_a_q, exp_a_d;
    logic [W-1:0]  exp_b_q, exp_b_d;
    logic [W-1:0]  cap_q, cap_d;
    logic          hunt_cnt_q, hunt_cnt_d;
    logic [3:0]    match_cnt_q, match_cnt_d;
    logic [3:0]    miss_cnt_q, miss_cnt_d;
    logic          locked_q, locked_d;
    logic          err_q, err_d;
    logic          lost_q, lost_d;
    logic [CW-1:0] err_count_q, err_count_d;

    logic          hit;
    logic          step_model;
    logic [3:0]    match_next;
    logic [3:0]    miss_next;

    // NOTE: every signal gets its default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        exp_a_d     = exp_a_q;
        exp_b_d     = exp_b_q;
        cap_d       = cap_q;
        hunt_cnt_d  = hunt_cnt_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_count_d = err_count_q;
        err_d       = 1'b0;
        lost_d      = 1'b0;
        step_model  = 1'b0;
        hit         = (obs_data == exp_a_q);
        match_next  = match_cnt_q + 4'd1;
        miss_next   = miss_cnt_q + 4'd1;

        case (state_q)
            ST_HUNT: begin
                if (obs_valid && obs_adv) begin
                    if (!hunt_cnt_q) begin
                        cap_d      = obs_data;
                        hunt_cnt_d = 1'b1;
                    end else begin
                        // Seed the model with the two terms that follow cap, obs_data.
                        exp_a_d     = cap_q + obs_data;
                        exp_b_d     = cap_q + obs_data + obs_data;
                        match_cnt_d = 4'd0;
                        hunt_cnt_d  = 1'b0;
                        state_d     = ST_VERIFY;
                    end
                end
            end
            ST_VERIFY: begin
                if (obs_valid) begin
                    step_model = 1'b1;
                    if (hit) begin
                        match_cnt_d = match_next;
                        if (match_next == LOCK_T) begin
                            state_d    = ST_LOCKED;
                            miss_cnt_d = 4'd0;
                        end
                    end else begin
                        state_d    = ST_HUNT;
                        hunt_cnt_d = 1'b0;
                    end
                end
            end
            ST_LOCKED: begin
                if (obs_valid) begin
                    step_model = 1'b1;
                    if (hit) begin
                        miss_cnt_d = 4'd0;
                    end else begin
                        err_d      = 1'b1;
                        miss_cnt_d = miss_next;
                        if (err_count_q != {CW{1'b1}}) begin
                            err_count_d = err_count_q + CW'(1);
                        end
                        if (miss_next == ERR_T) begin
                            lost_d     = 1'b1;
                            miss_cnt_d = 4'd0;
                            hunt_cnt_d = 1'b0;
                            state_d    = ST_HUNT;
                        end
                    end
                end
            end
            default: begin
                state_d    = ST_HUNT;
                hunt_cnt_d = 1'b0;
            end
        endcase

        // The model keeps tracking the generator even across a mismatch.
        if (step_model && obs_adv) begin
            exp_a_d = exp_b_q;
            exp_b_d = exp_a_q + exp_b_q;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            exp_a_q     <= '0;
            exp_b_q     <= '0;
            cap_q       <= '0;
            hunt_cnt_q  <= 1'b0;
            match_cnt_q <= 4'd0;
            miss_cnt_q  <= 4'd0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            lost_q      <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            exp_a_q     <= exp_a_d;
            exp_b_q     <= exp_b_d;
            cap_q       <= cap_d;
            hunt_cnt_q  <= hunt_cnt_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            lost_q      <= lost_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = locked_q;
    assign err       = err_q;
    assign lost      = lost_q;
    assign exp_data  = exp_a_q;
    assign err_count = err_count_q;

endmodule
